wb_select_stage: RTL and testbench

- Registered, parametrised write-back stage between the execute/memory side and the register file.
- Selects one of NUM_SRC result sources, applies load byte/half extraction with sign or zero extension, and suppresses writes to x0.
- Presents the result through a valid/ready handshake, with a 2-entry skid buffer so that in_ready_o is driven from a register.
- Also exports the head entry as a forwarding (bypass) source for the hazard unit.

---
 rtl/wb_pkg.sv | 43 ++++
 rtl/wb_skid_buffer.sv | 71 +++++++
 rtl/wb_select_stage.sv | 85 ++++++++
 tb/tb_wb_select_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back select stage: source indices,
// load sizes, the buffered entry layout and the load byte/half extraction.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam int SRC_PC  = 0;
  localparam int SRC_ALU = 1;
  localparam int SRC_MEM = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Extracts a byte or half from the low word and extends it to 32 bits;
  // word (and the unused 2'b11 encoding) returns the word untouched.
  function automatic logic [31:0] load_extract(input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = data[{offset, 3'b000} +: 8];
    h = data[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready buffer: a head register feeding the output and a
// skid register that catches one entry so in_ready_o can come from a flop.
module wb_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  // Handshake: a beat transfers on an edge where valid && ready are both high;
  // valid never depends combinationally on ready on either side.
  logic             head_valid_q, head_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = head_valid_q;
  assign out_data_o  = head_data_q;

  assign push = in_valid_i && !skid_valid_q;
  assign pop  = head_valid_q && out_ready_i;

  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_data_d  = head_data_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      if (skid_valid_q) begin
        // Skid is full so no push can happen; drain it into head.
        head_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        head_data_d = in_data_i;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      head_data_q  <= head_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back stage: picks a result source, extracts/extends loads, drops
// writes to x0, and buffers the entry for the register file and bypass path.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_W,
  parameter int NUM_SRC        = 3,
  parameter int SEL_WIDTH      = 2,
  parameter int MEM_SRC        = SRC_MEM,
  parameter int REG_ADDR_WIDTH = WB_ADDR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [SEL_WIDTH-1:0]          sel_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_i,
  input  logic                          we_i,
  input  logic [REG_ADDR_WIDTH-1:0]     rd_i,
  input  logic [1:0]                    mem_size_i,
  input  logic                          mem_unsigned_i,
  input  logic [1:0]                    mem_offset_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0]     rf_waddr_o,
  output logic [DATA_WIDTH-1:0]         rf_wdata_o,
  output logic                          fwd_valid_o,
  output logic [REG_ADDR_WIDTH-1:0]     fwd_addr_o,
  output logic [DATA_WIDTH-1:0]         fwd_data_o
);

  localparam int ENTRY_W = $bits(wb_entry_t);

  logic [DATA_WIDTH-1:0] raw_data, cap_data;
  logic [31:0]           ext32;
  logic                  sel_ok;
  logic                  is_sub_word;
  wb_entry_t             in_entry, head_entry;
  logic [ENTRY_W-1:0]    head_bits;
  logic                  head_valid;

  always_comb begin
    raw_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_i == SEL_WIDTH'(k)) begin
        raw_data = src_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_ok   = 1'b1;
      end
    end
    ext32       = load_extract(raw_data[31:0], mem_size_i, mem_offset_i, mem_unsigned_i);
    is_sub_word = (mem_size_i == SZ_BYTE) || (mem_size_i == SZ_HALF);
    cap_data    = raw_data;
    if ((sel_i == SEL_WIDTH'(MEM_SRC)) && is_sub_word) begin
      if (mem_unsigned_i) cap_data = DATA_WIDTH'(ext32);
      else                cap_data = DATA_WIDTH'($signed(ext32));
    end
    // Out-of-range selects produce zero data and never write.
    in_entry.we   = we_i && sel_ok && (rd_i != '0);
    in_entry.rd   = WB_ADDR_W'(rd_i);
    in_entry.data = WB_DATA_W'(cap_data);
  end

  wb_skid_buffer #(.WIDTH(ENTRY_W)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_entry),
    .out_valid_o (head_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (head_bits)
  );

  assign head_entry  = wb_entry_t'(head_bits);
  assign out_valid_o = head_valid;
  assign rf_we_o     = head_valid && out_ready_i && head_entry.we;
  assign rf_waddr_o  = head_valid ? REG_ADDR_WIDTH'(head_entry.rd) : '0;
  assign rf_wdata_o  = head_valid ? DATA_WIDTH'(head_entry.data) : '0;
  assign fwd_valid_o = head_valid && head_entry.we;
  assign fwd_addr_o  = fwd_valid_o ? REG_ADDR_WIDTH'(head_entry.rd) : '0;
  assign fwd_data_o  = fwd_valid_o ? DATA_WIDTH'(head_entry.data) : '0;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: source select, load extraction, x0 and
// bad-select suppression, stall ordering through the skid entry, mid-stall reset.
module tb_wb_select_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  sel_i;
  logic [95:0] src_i;
  logic        we_i;
  logic [4:0]  rd_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [1:0]  mem_offset_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  exp_addr_q[$];

  wb_select_stage dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .sel_i          (sel_i),
    .src_i          (src_i),
    .we_i           (we_i),
    .rd_i           (rd_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .mem_offset_i   (mem_offset_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .fwd_valid_o    (fwd_valid_o),
    .fwd_addr_o     (fwd_addr_o),
    .fwd_data_o     (fwd_data_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                       input logic [1:0] size, input logic uns, input logic [1:0] off);
    sel_i          = sel;
    we_i           = we;
    rd_i           = rd;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    mem_offset_i   = off;
  endtask

  task automatic send(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                      input logic [1:0] size, input logic uns, input logic [1:0] off);
    drive(sel, we, rd, size, uns, off);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_we"},    32'(rf_we_o), 32'd1);
    check({tag, "_addr"},  32'(rf_waddr_o), 32'(rd));
    check({tag, "_data"},  rf_wdata_o, data);
    check({tag, "_fdata"}, fwd_data_o, data);
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"pc",        2'd0, 2'b10, 1'b0, 2'd0, 32'h8000_0004};
    vecs[1] = '{"alu",       2'd1, 2'b10, 1'b0, 2'd0, 32'h0000_00AA};
    vecs[2] = '{"mem_word",  2'd2, 2'b10, 1'b0, 2'd0, 32'h1122_3384};
    vecs[3] = '{"lb_off0",   2'd2, 2'b00, 1'b0, 2'd0, 32'hFFFF_FF84};
    vecs[4] = '{"lbu_off0",  2'd2, 2'b00, 1'b1, 2'd0, 32'h0000_0084};
    vecs[5] = '{"lh_off2",   2'd2, 2'b01, 1'b0, 2'd2, 32'h0000_1122};
    vecs[6] = '{"lb_off3",   2'd2, 2'b00, 1'b0, 2'd3, 32'h0000_0011};
    vecs[7] = '{"lh_off1",   2'd2, 2'b01, 1'b0, 2'd1, 32'h0000_3384};
    vecs[8] = '{"lbu_off1",  2'd2, 2'b00, 1'b1, 2'd1, 32'h0000_0033};
    vecs[9] = '{"mem_sz11",  2'd2, 2'b11, 1'b0, 2'd0, 32'h1122_3384};

    src_i       = {32'h1122_3384, 32'h0000_00AA, 32'h8000_0004};
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    drive(2'd0, 1'b0, 5'd0, 2'b10, 1'b0, 2'd0);
    rst_ni = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_in_ready",  32'(in_ready_o), 32'd1);
    rst_ni = 1'b1;
    tick();
    check("idle_out_valid", 32'(out_valid_o), 32'd0);
    check("idle_in_ready",  32'(in_ready_o), 32'd1);
    check("idle_rf_we",     32'(rf_we_o), 32'd0);
    check("idle_waddr",     32'(rf_waddr_o), 32'd0);
    check("idle_wdata",     rf_wdata_o, 32'd0);
    check("idle_fwd_valid", 32'(fwd_valid_o), 32'd0);
    check("idle_fwd_data",  fwd_data_o, 32'd0);

    // Back-to-back entries, each written the cycle after capture.
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].sel, 1'b1, 5'd5, vecs[i].size, vecs[i].uns, vecs[i].off);
      check_write(vecs[i].tag, 5'd5, vecs[i].exp);
      check({vecs[i].tag, "_fvalid"}, 32'(fwd_valid_o), 32'd1);
    end
    tick();
    check("drain_out_valid", 32'(out_valid_o), 32'd0);

    // Suppressed writes: bad select and x0 destination.
    send(2'd3, 1'b1, 5'd5, 2'b10, 1'b0, 2'd0);
    check("sel3_out_valid", 32'(out_valid_o), 32'd1);
    check("sel3_rf_we",     32'(rf_we_o), 32'd0);
    check("sel3_fwd_valid", 32'(fwd_valid_o), 32'd0);
    check("sel3_wdata",     rf_wdata_o, 32'd0);
    send(2'd1, 1'b1, 5'd0, 2'b10, 1'b0, 2'd0);
    check("x0_out_valid", 32'(out_valid_o), 32'd1);
    check("x0_rf_we",     32'(rf_we_o), 32'd0);
    check("x0_fwd_valid", 32'(fwd_valid_o), 32'd0);
    check("x0_fwd_data",  fwd_data_o, 32'd0);
    check("x0_wdata",     rf_wdata_o, 32'h0000_00AA);
    tick();

    // Stall: A in head, B in skid, C held upstream.
    out_ready_i = 1'b0;
    send(2'd0, 1'b1, 5'd1, 2'b10, 1'b0, 2'd0);
    exp_q.push_back(32'h8000_0004); exp_addr_q.push_back(5'd1);
    check("stall_a_in_ready", 32'(in_ready_o), 32'd1);
    send(2'd1, 1'b1, 5'd2, 2'b10, 1'b0, 2'd0);
    exp_q.push_back(32'h0000_00AA); exp_addr_q.push_back(5'd2);
    drive(2'd2, 1'b1, 5'd3, 2'b10, 1'b0, 2'd0);
    exp_q.push_back(32'h1122_3384); exp_addr_q.push_back(5'd3);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready_o), 32'd0);
      check("stall_head",     rf_wdata_o, 32'h8000_0004);
      check("stall_rf_we",    32'(rf_we_o), 32'd0);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    begin
      int  n_wr;
      bit  acc;
      n_wr = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (rf_we_o) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            check("extra_write", 32'd1, 32'd0);
          end else begin
            check("order_data", rf_wdata_o, exp_q.pop_front());
            check("order_addr", 32'(rf_waddr_o), 32'(exp_addr_q.pop_front()));
          end
        end
        acc = in_valid_i && in_ready_o;
        tick();
        if (acc) in_valid_i = 1'b0;
      end
      check("order_count", 32'(n_wr), 32'd3);
      check("order_left",  32'(exp_q.size()), 32'd0);
    end

    // Reset mid-stall with both entries occupied.
    out_ready_i = 1'b0;
    send(2'd1, 1'b1, 5'd7, 2'b10, 1'b0, 2'd0);
    send(2'd0, 1'b1, 5'd8, 2'b10, 1'b0, 2'd0);
    check("full_in_ready", 32'(in_ready_o), 32'd0);
    #3;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready_o), 32'd1);
    check("mid_rst_wdata",     rf_wdata_o, 32'd0);
    check("mid_rst_fwd_valid", 32'(fwd_valid_o), 32'd0);
    out_ready_i = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    begin
      int n_wr;
      n_wr = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
        tick();
        if (rf_we_o) n_wr++;
      end
      check("post_rst_writes", 32'(n_wr), 32'd0);
      check("post_rst_valid",  32'(out_valid_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
